// File: rtl/pd_dwell_sequencer.sv
// pd_dwell_sequencer: runs one detector dwell at a time. It latches the
// threshold and dwell length, forces the detector out of any stale pulse
// (ARM), gates the detector enable for the dwell, and tracks the detector's
// pulse state with an internal copy of the detector rule (the mirror). When a
// pulse ends it captures the detector's {toa, pw, pa} into a first-word
// fall-through PDW FIFO that feeds a valid/ready stream.
// Optional statistics counters are built when PD_SEQ_STATS_EN is defined.
module pd_dwell_sequencer #(
  parameter int VIDEO_SIZE = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           dwell_cycles,
  input  logic [VIDEO_SIZE-1:0] threshold_in,
  input  logic [VIDEO_SIZE-1:0] video,
  output logic                  pd_enable,
  output logic [VIDEO_SIZE-1:0] pd_threshold,
  input  logic [31:0]           pd_pw,
  input  logic [31:0]           pd_pa,
  input  logic [31:0]           pd_toa,
  output logic                  pdw_valid,
  input  logic                  pdw_ready,
  output logic [31:0]           pdw_toa,
  output logic [31:0]           pdw_pw,
  output logic [31:0]           pdw_pa,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           drop_count,
  output logic [15:0]           pulse_count,
  output logic [2:0]            dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 96;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_DWELL = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    pd_enable_q, pd_enable_d;
  logic [VIDEO_SIZE-1:0]   pd_threshold_q, pd_threshold_d;
  logic                    done_q, done_d;
  logic [31:0]             dwell_len_q, dwell_len_d;
  logic [31:0]             cnt_q, cnt_d;
  logic                    mirror_q, mirror_d;
  logic                    mirror_end;
  logic                    cap_pend_q, cap_pend_d;
  logic                    start_acc;

  assign start_acc    = (state_q == S_IDLE) && start;
  assign pd_enable    = pd_enable_q;
  assign pd_threshold = pd_threshold_q;
  assign done         = done_q;
  assign busy         = (state_q != S_IDLE);
  assign dbg_state    = state_q;

  // Next-state logic: dwell sequencing plus the detector-rule mirror.
  always_comb begin
    state_d        = state_q;
    pd_enable_d    = pd_enable_q;
    pd_threshold_d = pd_threshold_q;
    done_d         = 1'b0;
    dwell_len_d    = dwell_len_q;
    cnt_d          = cnt_q;
    mirror_d       = mirror_q;
    mirror_end     = 1'b0;
    // The mirror only moves on edges where the detector itself is enabled.
    if (pd_enable_q) begin
      if (!mirror_q && (video >= pd_threshold_q)) begin
        mirror_d = 1'b1;
      end else if (mirror_q && (video < pd_threshold_q)) begin
        mirror_d   = 1'b0;
        mirror_end = 1'b1;
      end
    end
    // Pulses that end while arming are stale and are never captured.
    cap_pend_d = mirror_end && ((state_q == S_DWELL) || (state_q == S_FLUSH));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dwell_len_d    = (dwell_cycles == 32'd0) ? 32'd1 : dwell_cycles;
          pd_threshold_d = threshold_in;
          pd_enable_d    = 1'b1;
          state_d        = S_ARM;
        end
      end
      S_ARM: begin
        // A below-threshold enabled cycle guarantees the detector is idle.
        if (video < pd_threshold_q) begin
          cnt_d    = dwell_len_q;
          mirror_d = 1'b0;
          state_d  = S_DWELL;
        end
      end
      S_DWELL: begin
        if (cnt_q <= 32'd1) begin
          if (mirror_d) begin
            state_d = S_FLUSH;
          end else begin
            state_d     = S_DONE;
            pd_enable_d = 1'b0;
            done_d      = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_FLUSH: begin
        if (!mirror_d) begin
          state_d     = S_DONE;
          pd_enable_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        pd_enable_d = 1'b0;
      end
    endcase
    // Abort wins over every other transition; a pending capture is kept.
    if (stop && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      pd_enable_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  // FSM and mirror registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pd_enable_q    <= 1'b0;
      pd_threshold_q <= '0;
      done_q         <= 1'b0;
      dwell_len_q    <= 32'd1;
      cnt_q          <= 32'd1;
      mirror_q       <= 1'b0;
      cap_pend_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pd_enable_q    <= pd_enable_d;
      pd_threshold_q <= pd_threshold_d;
      done_q         <= done_d;
      dwell_len_q    <= dwell_len_d;
      cnt_q          <= cnt_d;
      mirror_q       <= mirror_d;
      cap_pend_q     <= cap_pend_d;
    end
  end

  // PDW stream: pdw_valid means the head entry is on pdw_*; the entry is
  // consumed on any rising edge where pdw_valid && pdw_ready. pdw_* stay
  // stable until that pop (or until a write lands in an empty FIFO).
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, full, push_ok;

  assign pdw_valid = (count_q != '0);
  assign {pdw_toa, pdw_pw, pdw_pa} = mem_q[rd_ptr_q];

  // FIFO bookkeeping; a pop in the same cycle frees room for a push when full.
  always_comb begin
    push     = cap_pend_q;
    pop      = pdw_valid && pdw_ready;
    full     = (count_q == FULL_CNT);
    push_ok  = push && (!full || pop);
    wr_ptr_d = push_ok ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
  end

  // FIFO storage and pointers; storage resets so pdw_* read 0 after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= {pd_toa, pd_pw, pd_pa};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef PD_SEQ_STATS_EN
  logic [15:0] pulse_count_q, pulse_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  // Saturating per-dwell statistics, cleared when a dwell is started.
  always_comb begin
    pulse_count_d = pulse_count_q;
    drop_count_d  = drop_count_q;
    if (start_acc) begin
      pulse_count_d = '0;
      drop_count_d  = '0;
    end else begin
      if (push && (pulse_count_q != 16'hFFFF)) pulse_count_d = pulse_count_q + 16'd1;
      if (push && !push_ok && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pulse_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      pulse_count_q <= pulse_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign pulse_count = pulse_count_q;
  assign drop_count  = drop_count_q;
`else
  assign pulse_count = 16'd0;
  assign drop_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pd_dwell_sequencer.sv
// Bench for pd_dwell_sequencer: a behavioural detector drives pd_pw/pa/toa,
// a per-dwell reference walk over the video array predicts PDWs, dwell length
// and done timing, and a scoreboard queue is checked by a negedge monitor.
`timescale 1ns/1ps
module tb_pd_dwell_sequencer;
  localparam int VS    = 10;
  localparam int DEPTH = 4;
  localparam int W     = 96;

  logic           clock;
  logic           reset;
  logic           start, stop, pdw_ready;
  logic [31:0]    dwell_cycles;
  logic [VS-1:0]  threshold_in, video;
  logic           pd_enable;
  logic [VS-1:0]  pd_threshold;
  logic [31:0]    pd_pw, pd_pa, pd_toa;
  logic           pdw_valid;
  logic [31:0]    pdw_toa, pdw_pw, pdw_pa;
  logic           busy, done;
  logic [15:0]    drop_count, pulse_count;
  logic [2:0]     dbg_state;

  int vectors = 0;
  int miscompares = 0;

  pd_dwell_sequencer #(.VIDEO_SIZE(VS), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .dwell_cycles(dwell_cycles), .threshold_in(threshold_in), .video(video),
    .pd_enable(pd_enable), .pd_threshold(pd_threshold),
    .pd_pw(pd_pw), .pd_pa(pd_pa), .pd_toa(pd_toa),
    .pdw_valid(pdw_valid), .pdw_ready(pdw_ready),
    .pdw_toa(pdw_toa), .pdw_pw(pdw_pw), .pdw_pa(pdw_pa),
    .busy(busy), .done(done), .drop_count(drop_count),
    .pulse_count(pulse_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard state
  typedef struct packed {logic [31:0] at; logic [W-1:0] word;} push_t;
  typedef struct packed {logic [31:0] ke; logic [W-1:0] word;} rec_t;
  push_t         pend_q[$];
  logic [W-1:0]  exp_q[$];
  rec_t          recs[$];
  logic [31:0]   cyc;
  logic [31:0]   c0;
  logic          det_act;
  int            dwell_drops;

  // behavioural detector, cycle stamp and FIFO-admission model
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      det_act <= 1'b0;
      pd_pw   <= '0;
      pd_pa   <= '0;
      pd_toa  <= '0;
      cyc     <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (pd_enable) begin
        if (!det_act && (video >= pd_threshold)) begin
          det_act <= 1'b1;
          pd_pw   <= 32'd1;
          pd_pa   <= 32'(video);
          pd_toa  <= cyc;
        end else if (det_act && (video >= pd_threshold)) begin
          pd_pw <= pd_pw + 32'd1;
          if (32'(video) > pd_pa) pd_pa <= 32'(video);
        end else if (det_act) begin
          det_act <= 1'b0;
        end
      end
      if (pend_q.size() > 0 && pend_q[0].at == cyc) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(pend_q[0].word);
        else dwell_drops++;
        void'(pend_q.pop_front());
      end
    end
  end

  // monitor: per-cycle observations and PDW scoreboard pops
  int          en_cnt, busy_cnt, done_cnt;
  logic [31:0] done_at;
  always @(negedge clock) begin
    if (!reset) begin
      if (pd_enable) en_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      chk("pdw_valid", W'(pdw_valid), W'(exp_q.size() != 0));
      if (pdw_valid && pdw_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pdw_pop: got %0h expected no entry", {pdw_toa, pdw_pw, pdw_pa});
        end else begin
          chk("pdw_word", {pdw_toa, pdw_pw, pdw_pa}, exp_q.pop_front());
        end
      end
    end
  end

  // stimulus video, indexed by edge number after the start edge
  logic [VS-1:0] vid [256];

  function automatic logic [VS-1:0] hi(input int thr);
    return VS'($urandom_range(1023, thr));
  endfunction

  function automatic logic [VS-1:0] lo(input int thr);
    return VS'($urandom_range(thr - 1, 0));
  endfunction

  task automatic clear_vid();
    for (int k = 0; k < 256; k++) vid[k] = '0;
  endtask

  // reference: ARM exit edge, dwell end edge and every pulse ending after ARM
  task automatic ref_walk(input int thr, input int neff, output int a, output int e_end);
    int k, ks;
    bit act;
    logic [31:0] pw, pa;
    recs.delete();
    a = 1;
    while (vid[a] >= thr) a++;
    act = 0; e_end = 0; k = a + 1; ks = 0; pw = 0; pa = 0;
    while (e_end == 0) begin
      if (vid[k] >= thr) begin
        if (!act) begin
          act = 1; ks = k; pw = 1; pa = 32'(vid[k]);
        end else begin
          pw++;
          if (32'(vid[k]) > pa) pa = 32'(vid[k]);
        end
      end else if (act) begin
        act = 0;
        recs.push_back('{ke: 32'(k), word: {c0 + 32'(ks), pw, pa}});
      end
      if (k >= a + neff && !act) e_end = k;
      k++;
    end
  endtask

  // driver: one dwell. stop_at 0 none, -1 random, else that edge.
  // rdy_mode 0 random ready, 1 ready low, 2 ready only at the fifth push edge.
  task automatic run_dwell(input int thr, input int n, input int stop_at, input int rdy_mode);
    int a, e, s, lim, neff, npush;
    logic [31:0] pop_at;
    neff = (n == 0) ? 1 : n;
    c0 = cyc;
    ref_walk(thr, neff, a, e);
    s = 0;
    if (stop_at < 0) s = $urandom_range(e, 1);
    else if (stop_at > 0) s = (stop_at > e) ? e : stop_at;
    lim = (s != 0) ? s : e;
    npush = 0;
    foreach (recs[i]) begin
      if (recs[i].ke <= 32'(lim)) begin
        pend_q.push_back('{at: c0 + recs[i].ke + 32'd1, word: recs[i].word});
        npush++;
      end
    end
    pop_at = (pend_q.size() >= 5) ? pend_q[4].at : 32'hFFFF_FFFF;
    en_cnt = 0; busy_cnt = 0; done_cnt = 0; dwell_drops = 0; done_at = '0;
    start = 1'b1;
    dwell_cycles = 32'(n);
    threshold_in = VS'(thr);
    video = '0;
    pdw_ready = (rdy_mode == 0) ? ($urandom_range(3, 0) != 0) : 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= lim + 3; k++) begin
      video = (k <= lim) ? vid[k] : '0;
      stop  = (k == s);
      if (rdy_mode == 0) pdw_ready = ($urandom_range(3, 0) != 0);
      else if (rdy_mode == 1) pdw_ready = 1'b0;
      else pdw_ready = (cyc == pop_at);
      @(posedge clock); #1;
    end
    stop = 1'b0;
    video = '0;
    chk("enabled_cycles", W'(en_cnt), W'(lim));
    chk("busy_cycles", W'(busy_cnt), W'((s != 0) ? s : e + 1));
    chk("done_pulses", W'(done_cnt), W'((s != 0) ? 0 : 1));
    if (s == 0) chk("done_time", W'(done_at), W'(c0 + 32'(e) + 32'd1));
    chk("state_idle", W'(dbg_state), W'(0));
`ifdef PD_SEQ_STATS_EN
    chk("pulse_count", W'(pulse_count), W'(npush));
    chk("drop_count", W'(drop_count), W'(dwell_drops));
`else
    chk("pulse_count", W'(pulse_count), W'(0));
    chk("drop_count", W'(drop_count), W'(0));
`endif
    pdw_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clock); #1;
    end
    chk("drain", W'(exp_q.size()), W'(0));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; stop = 1'b0; pdw_ready = 1'b0;
    dwell_cycles = '0; threshold_in = '0; video = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_pd_enable", W'(pd_enable), W'(0));
    chk("rst_pd_threshold", W'(pd_threshold), W'(0));
    chk("rst_pdw_valid", W'(pdw_valid), W'(0));
    chk("rst_pdw_word", {pdw_toa, pdw_pw, pdw_pa}, W'(0));
    chk("rst_busy_done", W'({busy, done}), W'(0));
    chk("rst_counts", W'({drop_count, pulse_count}), W'(0));
    chk("rst_state", W'(dbg_state), W'(0));
    @(posedge clock); #1;

    // video high at start: ARM holds, then exactly 20 dwell cycles, no PDW
    clear_vid();
    for (int k = 1; k <= 5; k++) vid[k] = 10'd500;
    run_dwell(100, 20, 0, 0);

    // single 5-cycle pulse of amplitude 300
    clear_vid();
    for (int k = 3; k <= 7; k++) vid[k] = 10'd300;
    run_dwell(100, 50, 0, 0);

    // pulse still active when the counter expires: FLUSH, PW=7
    clear_vid();
    for (int k = 9; k <= 15; k++) vid[k] = 10'd400;
    run_dwell(100, 10, 0, 0);

    // six one-cycle pulses with the consumer stalled: four stored, two dropped
    clear_vid();
    for (int i = 0; i < 6; i++) vid[3 + 3*i] = 10'd250;
    run_dwell(100, 40, 0, 1);

    // abort during a pulse, then re-arm over the stale pulse
    clear_vid();
    for (int k = 5; k <= 12; k++) vid[k] = 10'd600;
    run_dwell(100, 30, 8, 0);
    clear_vid();
    for (int k = 1; k <= 3; k++) vid[k] = 10'd700;
    vid[8] = 10'd150;
    run_dwell(100, 12, 0, 0);

    // pop and push together while full
    clear_vid();
    for (int i = 0; i < 7; i++) vid[3 + 3*i] = 10'd350;
    run_dwell(100, 40, 0, 2);

    // dwell length 0 behaves as 1
    clear_vid();
    run_dwell(200, 0, 0, 0);

    // randomized dwells
    for (int r = 0; r < 30; r++) begin
      int thr, n, p, st, md;
      thr = $urandom_range(1000, 1);
      n   = $urandom_range(40, 0);
      p   = $urandom_range(4, 0);
      clear_vid();
      for (int k = 1; k <= p; k++) vid[k] = hi(thr);
      vid[p + 1] = lo(thr);
      for (int k = p + 2; k <= p + n + 10; k++) vid[k] = ($urandom_range(2, 0) == 0) ? hi(thr) : lo(thr);
      st = ($urandom_range(4, 0) == 0) ? -1 : 0;
      md = ($urandom_range(3, 0) == 0) ? 1 : 0;
      run_dwell(thr, n, st, md);
    end

    chk("pend_empty", W'(pend_q.size()), W'(0));
    chk("exp_empty", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
